// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, 8N1 frames (8E1 when parity is
// compiled in), LSB first. The line is synchronised and the start bit is
// validated at mid-bit. Every later bit is sampled at mid-period. Each good
// byte is presented on rx_data_o together with a one-cycle rx_valid_o strobe.
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit. When it is undefined, the parity
// state is not built and parity_err_o is tied low.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   rx_i         raw serial line, asynchronous to clk_i, idle high
//   rx_data_o    last correctly received byte, held between frames
//   rx_valid_o   one-cycle strobe, rx_data_o is new in that cycle
//   frame_err_o  one-cycle strobe, stop bit sampled low
//   parity_err_o one-cycle strobe, even-parity mismatch
//   rx_busy_o    high whenever the receiver is not idle
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       rx_busy_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          sync1_q, rx_s_q;
`ifdef UART_RX_PARITY_EN
  logic          perr_q, perr_d;
  logic          par_bad_q, par_bad_d;
`endif

  // Two-flop synchroniser. Both flops reset high so that a reset does not
  // look like a falling edge on the line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      rx_s_q  <= sync1_q;
    end
  end

  // Receiver state and the registered output strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Next-state logic. The start bit is checked at half a bit so that every
  // later sample, taken a full bit apart, lands mid-bit. The stop-bit sample
  // returns straight to idle, which leaves half a bit of slack before the
  // next start edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = rx_s_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          par_bad_d = ^{shift_q, rx_s_q};
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
`else
            valid_d = 1'b1;
            data_d  = shift_q;
`endif
          end else begin
            // A low stop bit wins over a parity error; only frame_err fires.
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // Hold off until the line returns high so a held-low line is not
        // decoded as a stream of zero bytes.
        cnt_d = '0;
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;
  assign rx_busy_o   = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with CLKS_PER_BIT = 16.
// Frames are described at bit level and driven onto the line. A frame-level
// reference model predicts each strobe from the frame contents: its kind, the
// cycle at which it appears, and the byte held on rx_data at that time.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int N = 16;
  localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam bit PARITY_ON  = 1'b1;
`else
  localparam int FRAME_BITS = 10;
  localparam bit PARITY_ON  = 1'b0;
`endif
  // Two synchroniser flops plus the idle-detect edge reach E0. The stop bit
  // is then sampled H + (FRAME_BITS-1)*N edges later.
  localparam int LAT = 3 + H + (FRAME_BITS - 1) * N;
  localparam int K_VALID = 1;
  localparam int K_FERR  = 2;
  localparam int K_PERR  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rxData;
  logic       rxValid, frameErr, parityErr, rxBusy;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         overlapCount = 0;
  logic       monOn = 1'b0;
  logic [7:0] lastGood = 8'h00;

  int         evKind[$];
  int         evCyc[$];
  logic [7:0] evData[$];
  int         exKind[$];
  int         exCyc[$];
  logic [7:0] exData[$];

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_i         (rx),
    .rx_data_o    (rxData),
    .rx_valid_o   (rxValid),
    .frame_err_o  (frameErr),
    .parity_err_o (parityErr),
    .rx_busy_o    (rxBusy)
  );

  // 100 MHz clock and a free-running cycle counter used to timestamp strobes.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: sampled on the falling edge, it logs every strobe cycle
  // so that a stretched pulse shows up as an extra event.
  always @(negedge clk) begin
    if (monOn && !rst) begin
      if (int'(rxValid) + int'(frameErr) + int'(parityErr) > 1) overlapCount++;
      if (rxValid === 1'b1) begin
        evKind.push_back(K_VALID); evCyc.push_back(cyc); evData.push_back(rxData);
      end
      if (frameErr === 1'b1) begin
        evKind.push_back(K_FERR); evCyc.push_back(cyc); evData.push_back(rxData);
      end
      if (parityErr === 1'b1) begin
        evKind.push_back(K_PERR); evCyc.push_back(cyc); evData.push_back(rxData);
      end
    end
  end

  // One comparison: counts it, and reports and counts a failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Holds the line at one level for a number of bit-clock cycles.
  task automatic driveBit(input logic v, input int cycles);
    rx = v;
    repeat (cycles) @(negedge clk);
  endtask

  // Reference model for one complete frame driven starting at cycle 'start'.
  function automatic void expectFrame(input logic [7:0] b, input logic parBit,
                                      input logic stopBit, input int start);
    int kind;
    if (!stopBit) kind = K_FERR;
    else if (PARITY_ON && ((^b) != parBit)) kind = K_PERR;
    else begin
      kind     = K_VALID;
      lastGood = b;
    end
    exKind.push_back(kind);
    exCyc.push_back(start + LAT);
    exData.push_back(lastGood);
  endfunction

  // Drives one full frame on the line and records what the model expects.
  task automatic applyStimulus(input logic [7:0] b, input logic parBit,
                               input logic stopBit);
    int start;
    start = cyc;
    driveBit(1'b0, N);
    for (int i = 0; i < 8; i++) driveBit(b[i], N);
    if (PARITY_ON) driveBit(parBit, N);
    driveBit(stopBit, N);
    expectFrame(b, parBit, stopBit, start);
  endtask

  // Compares the logged strobes with the model's predictions, then clears both.
  task automatic checkEvents(input string tag);
    checkOutput({tag, ".count"}, evKind.size(), exKind.size());
    for (int i = 0; i < exKind.size() && i < evKind.size(); i++) begin
      checkOutput($sformatf("%s.kind%0d", tag, i), evKind[i], exKind[i]);
      checkOutput($sformatf("%s.cycle%0d", tag, i), evCyc[i], exCyc[i]);
      checkOutput($sformatf("%s.data%0d", tag, i), evData[i], exData[i]);
    end
    evKind.delete(); evCyc.delete(); evData.delete();
    exKind.delete(); exCyc.delete(); exData.delete();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".rx_data"}, rxData, 8'h00);
    checkOutput({tag, ".rx_valid"}, rxValid, 1'b0);
    checkOutput({tag, ".frame_err"}, frameErr, 1'b0);
    checkOutput({tag, ".parity_err"}, parityErr, 1'b0);
    checkOutput({tag, ".rx_busy"}, rxBusy, 1'b0);
  endtask

  // Directed scenarios followed by a randomized frame stream.
  initial begin
    int         start;
    int         gap;
    logic [7:0] b;
    logic       stopBit;
    logic       parBit;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst   = 1'b0;
    monOn = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte.
    applyStimulus(8'hA5, 1'b0, 1'b1);
    driveBit(1'b1, N);
    checkEvents("single");
    checkOutput("single.hold", rxData, 8'hA5);

    // Back-to-back frames with no idle gap.
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'hFF, 1'b0, 1'b1);
    driveBit(1'b1, N);
    if (evCyc.size() == 2) checkOutput("b2b.spacing", evCyc[1] - evCyc[0], FRAME_BITS * N);
    checkEvents("b2b");

    // A four-cycle glitch must be rejected at the mid-start check.
    start = cyc;
    driveBit(1'b0, 4);
    driveBit(1'b1, 6);
    checkOutput("glitch.busy_high", rxBusy, 1'b1);
    driveBit(1'b1, 1);
    checkOutput("glitch.busy_low", rxBusy, 1'b0);
    checkOutput("glitch.elapsed", cyc - start, 3 + H);
    driveBit(1'b1, N);
    checkEvents("glitch");

    // Framing error followed by a long break, then a clean byte.
    rst = 1'b1;
    driveBit(1'b1, 2);
    rst      = 1'b0;
    lastGood = 8'h00;
    driveBit(1'b1, 2);
    applyStimulus(8'h3C, 1'b0, 1'b0);
    driveBit(1'b0, 100);
    checkOutput("break.busy", rxBusy, 1'b1);
    driveBit(1'b1, 2 * N);
    applyStimulus(8'h55, 1'b0, 1'b1);
    driveBit(1'b1, N);
    checkEvents("break");
    checkOutput("break.rx_data", rxData, 8'h55);

    // Reset in the middle of bit 3 of 0x81, then a fresh byte.
    driveBit(1'b0, N);
    driveBit(1'b1, N);
    driveBit(1'b0, N);
    driveBit(1'b0, N);
    driveBit(1'b0, H);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    checkResetValues("midreset");
    lastGood = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    driveBit(1'b1, 2 * N);
    checkResetValues("midreset.release");
    applyStimulus(8'h42, 1'b0, 1'b1);
    driveBit(1'b1, N);
    checkEvents("midreset");

    // Parity good then bad. Without parity both frames are plain valid bytes.
    applyStimulus(8'h03, 1'b0, 1'b1);
    applyStimulus(8'h03, 1'b1, 1'b1);
    driveBit(1'b1, N);
    checkEvents("parity");
    checkOutput("parity.rx_data", rxData, 8'h03);

    // Randomized frames: random data, occasional bad stop or parity bit and
    // random idle gaps. After a bad stop bit the line goes high for at least
    // two cycles so the receiver can leave the break state.
    for (int i = 0; i < 16; i++) begin
      b       = 8'($urandom);
      stopBit = ($urandom_range(0, 7) != 0);
      parBit  = (^b) ^ ($urandom_range(0, 5) == 0);
      applyStimulus(b, parBit, stopBit);
      gap = stopBit ? int'($urandom_range(0, N)) : int'($urandom_range(2, N));
      if (gap > 0) driveBit(1'b1, gap);
    end
    driveBit(1'b1, N);
    checkEvents("random");

    checkOutput("strobe_overlap", overlapCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
